// File: rtl/noise_envelope_shaper_pkg.sv
// Shared types and constants for the noise envelope shaper.
//   env_state_t  : envelope FSM states
//   noise_kind_t : which sound is playing (sets the decay rate)
//   ENV_MAX      : full-scale envelope/sample level for the default 8-bit width
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ATTACK = 2'd1,
    DECAY  = 2'd2
  } env_state_t;

  typedef enum logic {
    EXPLO = 1'b0,
    SHELL = 1'b1
  } noise_kind_t;

  localparam int ENV_W_DEF = 8;
  localparam int ENV_MAX   = (2 ** ENV_W_DEF) - 1;

endpackage

// File: rtl/noise_env_gen.sv
// Attack/decay envelope generator for the explosion and shell sounds.
// Ports:
//   clk, rst_n    : system clock, async active-low reset
//   i_env_en      : envelope step strobe
//   i_trig_explo  : one-clk pulse, start explosion (wins over shell)
//   i_trig_shell  : one-clk pulse, start shell
//   o_env         : current envelope level
//   o_active      : high while the FSM is not IDLE
module noise_env_gen
  import sound_pkg::*;
#(
  parameter int ENV_W       = 8,
  parameter int ATTACK_STEP = 32,
  parameter int EXPLO_DIV   = 4,
  parameter int SHELL_DIV   = 1,
  parameter int DIV_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_env_en,
  input  logic             i_trig_explo,
  input  logic             i_trig_shell,
  output logic [ENV_W-1:0] o_env,
  output logic             o_active
);

  localparam logic [ENV_W-1:0] MAX  = '1;
  localparam logic [ENV_W:0]   STEP = (ENV_W+1)'(ATTACK_STEP);

  env_state_t       r_state;
  noise_kind_t      r_kind;
  logic [ENV_W-1:0] r_env;
  logic [DIV_W-1:0] r_div;
  logic             r_active;

  logic [ENV_W:0]   w_sum;
  logic [DIV_W-1:0] w_div_last;
  logic             w_trig;

  // One extra bit so the saturation test sees the carry.
  assign w_sum      = {1'b0, r_env} + STEP;
  assign w_div_last = (r_kind == EXPLO) ? DIV_W'(EXPLO_DIV - 1) : DIV_W'(SHELL_DIV - 1);
  assign w_trig     = i_trig_explo | i_trig_shell;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_kind   <= EXPLO;
      r_env    <= '0;
      r_div    <= '0;
      r_active <= 1'b0;
    end else if (w_trig) begin
      // Env is kept: a retrigger ramps up from wherever it is now.
      r_state  <= ATTACK;
      r_kind   <= i_trig_explo ? EXPLO : SHELL;
      r_div    <= '0;
      r_active <= 1'b1;
    end else if (i_env_en) begin
      case (r_state)
        ATTACK: begin
          if (w_sum >= {1'b0, MAX}) begin
            r_env   <= MAX;
            r_state <= DECAY;
            r_div   <= '0;
          end else begin
            r_env <= w_sum[ENV_W-1:0];
          end
        end
        DECAY: begin
          if (r_div == w_div_last) begin
            r_div <= '0;
            // Last decrement (or an already-empty env) ends the sound.
            if (r_env <= ENV_W'(1)) begin
              r_env    <= '0;
              r_state  <= IDLE;
              r_active <= 1'b0;
            end else begin
              r_env <= r_env - 1'b1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_env    = r_env;
  assign o_active = r_active;

endmodule

// File: rtl/noise_envelope_shaper.sv
// Gates the serial noise bit with the attack/decay envelope and smooths the
// result with a one-pole IIR into an unsigned audio sample.
// Ports:
//   clk, rst_n     : system clock, async active-low reset
//   clk_12KHz_en   : filter sample strobe
//   clk_env_en     : envelope step strobe
//   rnoise         : serial noise bit
//   trig_explo     : start explosion
//   trig_shell     : start shell
//   loud           : 1 = gate at env, 0 = gate at env>>1
//   sample         : filtered sample (registered)
//   active         : sound in progress (registered)
module noise_envelope_shaper
  import sound_pkg::*;
#(
  parameter int ENV_W       = 8,
  parameter int ATTACK_STEP = 32,
  parameter int EXPLO_DIV   = 4,
  parameter int SHELL_DIV   = 1,
  parameter int FILT_SHIFT  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_12KHz_en,
  input  logic             clk_env_en,
  input  logic             rnoise,
  input  logic             trig_explo,
  input  logic             trig_shell,
  input  logic             loud,
  output logic [ENV_W-1:0] sample,
  output logic             active
);

  localparam logic [ENV_W-1:0] MAX = '1;

  logic [ENV_W-1:0]        w_env;
  logic [ENV_W-1:0]        w_x;
  logic signed [ENV_W+1:0] w_diff;
  logic signed [ENV_W+1:0] w_step;
  logic signed [ENV_W+1:0] w_sum;
  logic [ENV_W-1:0]        w_filt_nxt;
  logic [ENV_W-1:0]        r_filt;

  noise_env_gen #(
    .ENV_W       (ENV_W),
    .ATTACK_STEP (ATTACK_STEP),
    .EXPLO_DIV   (EXPLO_DIV),
    .SHELL_DIV   (SHELL_DIV),
    .DIV_W       (8)
  ) u_env (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_env_en     (clk_env_en),
    .i_trig_explo (trig_explo),
    .i_trig_shell (trig_shell),
    .o_env        (w_env),
    .o_active     (active)
  );

  // Gate uses the registered (pre-update) env when both strobes coincide.
  assign w_x = rnoise ? (loud ? w_env : {1'b0, w_env[ENV_W-1:1]}) : '0;

  // Two guard bits: one for sign, one for headroom on the sum.
  assign w_diff = $signed({2'b00, w_x}) - $signed({2'b00, r_filt});
  assign w_step = w_diff >>> FILT_SHIFT;
  assign w_sum  = $signed({2'b00, r_filt}) + w_step;

  always_comb begin
    w_filt_nxt = w_sum[ENV_W-1:0];
    if (w_sum < 0)                            w_filt_nxt = '0;
    else if (w_sum > $signed({2'b00, MAX}))   w_filt_nxt = MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_filt <= '0;
    else if (clk_12KHz_en) r_filt <= w_filt_nxt;
  end

  assign sample = r_filt;

endmodule
